// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - serialises two issue-lane data accesses onto one memory port
// Lane 0 is the older instruction and always retires first; the pipeline stalls until both finish.
module dmem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          l0_req,
  input  logic          l1_req,
  input  logic          l0_we,
  input  logic          l1_we,
  input  logic [AW-1:0] l0_addr,
  input  logic [AW-1:0] l1_addr,
  input  logic [DW-1:0] l0_wdata,
  input  logic [DW-1:0] l1_wdata,
  output logic [DW-1:0] l0_rdata,
  output logic [DW-1:0] l1_rdata,
  output logic          stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   stall_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, FIN} state_e;

  state_e        state_q, state_d;
  logic          pend1_q, pend1_d;
  logic [DW-1:0] l0_rdata_q, l0_rdata_d;
  logic [DW-1:0] l1_rdata_q, l1_rdata_d;
  logic [15:0]   stall_cnt_q, stall_cnt_d;
  logic          stall_raw;

  always_comb begin
    state_d    = state_q;
    pend1_d    = pend1_q;
    l0_rdata_d = l0_rdata_q;
    l1_rdata_d = l1_rdata_q;
    stall_raw  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        stall_raw = l0_req | l1_req;
        if (l0_req) begin
          state_d = BUSY0;
          pend1_d = l1_req;
        end else if (l1_req) begin
          state_d = BUSY1;
        end
      end
      BUSY0: begin
        stall_raw = 1'b1;
        mem_req   = 1'b1;
        mem_we    = l0_we;
        mem_addr  = l0_addr;
        mem_wdata = l0_wdata;
        if (mem_ready) begin
          if (!l0_we) l0_rdata_d = mem_rdata;
          state_d = pend1_q ? BUSY1 : FIN;
          pend1_d = 1'b0;
        end
      end
      BUSY1: begin
        stall_raw = 1'b1;
        mem_req   = 1'b1;
        mem_we    = l1_we;
        mem_addr  = l1_addr;
        mem_wdata = l1_wdata;
        if (mem_ready) begin
          if (!l1_we) l1_rdata_d = mem_rdata;
          state_d = FIN;
        end
      end
      // Lanes still hold the completed requests here; they must not be reissued.
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign stall       = reset & stall_raw;
  assign stall_cnt_d = (stall && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pend1_q     <= 1'b0;
      l0_rdata_q  <= '0;
      l1_rdata_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend1_q     <= pend1_d;
      l0_rdata_q  <= l0_rdata_d;
      l1_rdata_q  <= l1_rdata_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign l0_rdata  = l0_rdata_q;
  assign l1_rdata  = l1_rdata_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - scoreboard bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
  } acc_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        l0_req, l1_req, l0_we, l1_we;
  logic [31:0] l0_addr, l1_addr, l0_wdata, l1_wdata;
  logic [31:0] l0_rdata, l1_rdata;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [15:0] stall_cnt;

  int          checks = 0;
  int          failures = 0;
  acc_t        sb[$];
  logic [31:0] mem [logic [31:0]];
  bit          force_ready = 1'b0;
  int          exp_cnt = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .l0_req(l0_req), .l1_req(l1_req), .l0_we(l0_we), .l1_we(l1_we),
    .l0_addr(l0_addr), .l1_addr(l1_addr), .l0_wdata(l0_wdata), .l1_wdata(l1_wdata),
    .l0_rdata(l0_rdata), .l1_rdata(l1_rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
  );

  // Memory model: retires the scoreboard head after its latency and checks the presented attributes.
  task automatic responder();
    int   wait_cnt;
    acc_t e;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (force_ready) begin
        mem_ready = 1'b1;
      end else if (reset && mem_req) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_access: got addr=%h we=%b, expected no access", mem_addr, mem_we);
        end else begin
          wait_cnt++;
          if (wait_cnt >= sb[0].lat) begin
            e = sb.pop_front();
            wait_cnt = 0;
            checks++;
            if ({mem_we, mem_addr, mem_wdata} !== {e.we, e.addr, e.wdata}) begin
              failures++;
              $display("FAIL sb_access: got we=%b addr=%h wdata=%h, expected we=%b addr=%h wdata=%h",
                       mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
            end
            if (mem_we) mem[mem_addr] = mem_wdata;
            else mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
            mem_ready = 1'b1;
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  endtask

  // Drives one bundle and counts stalled cycles until FIN; leaves the bench sampling in FIN.
  task automatic drive_bundle(input logic r0, input logic we0, input logic [31:0] a0, input logic [31:0] d0, input int k0,
                              input logic r1, input logic we1, input logic [31:0] a1, input logic [31:0] d1, input int k1,
                              output int n, output bit done);
    l0_req = r0; l0_we = we0; l0_addr = a0; l0_wdata = d0;
    l1_req = r1; l1_we = we1; l1_addr = a1; l1_wdata = d1;
    if (r0) sb.push_back('{we0, a0, d0, k0});
    if (r1) sb.push_back('{we1, a1, d1, k1});
    n = 0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      if (stall) begin
        n++;
        @(posedge clk); #1;
      end else begin
        done = 1'b1;
      end
    end
  endtask

  task automatic release_lanes();
    @(posedge clk); #1;
    l0_req = 1'b0; l1_req = 1'b0;
  endtask

  task automatic check_fin(input string name, input int n, input bit done, input int exp_n,
                           input logic [31:0] exp_r0, input logic [31:0] exp_r1);
    exp_cnt += exp_n;
    checks++;
    if (!done) begin failures++; $display("FAIL %s_timeout: got no FIN within bound, expected FIN", name); end
    checks++;
    if (n !== exp_n) begin failures++; $display("FAIL %s_stall_cycles: got %0d, expected %0d", name, n, exp_n); end
    checks++;
    if (mem_req !== 1'b0) begin failures++; $display("FAIL %s_fin_mem_req: got %b, expected 0", name, mem_req); end
    checks++;
    if (l0_rdata !== exp_r0) begin failures++; $display("FAIL %s_l0_rdata: got %h, expected %h", name, l0_rdata, exp_r0); end
    checks++;
    if (l1_rdata !== exp_r1) begin failures++; $display("FAIL %s_l1_rdata: got %h, expected %h", name, l1_rdata, exp_r1); end
    checks++;
    if (stall_cnt !== exp_cnt[15:0]) begin failures++; $display("FAIL %s_stall_cnt: got %0d, expected %0d", name, stall_cnt, exp_cnt); end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL %s_pending: got %0d unretired, expected 0", name, sb.size()); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    l0_req = 1'b1; l1_req = 1'b1; l0_we = 1'b0; l1_we = 1'b0;
    l0_addr = 32'h0; l1_addr = 32'h0; l0_wdata = 32'h0; l1_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall_forced: got %b, expected 0", stall); end
    checks++;
    if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req: got %b, expected 0", mem_req); end
    checks++;
    if ({stall_cnt, l0_rdata, l1_rdata} !== 80'h0) begin
      failures++; $display("FAIL reset_regs: got cnt=%h r0=%h r1=%h, expected all 0", stall_cnt, l0_rdata, l1_rdata);
    end
    l0_req = 1'b0; l1_req = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b0) begin
      failures++; $display("FAIL reset_idle: got stall=%b mem_req=%b, expected 0 0", stall, mem_req);
    end
  endtask

  task automatic test_single_load();
    int n; bit done;
    drive_bundle(1'b1, 1'b0, 32'h8, 32'h0, 2, 1'b0, 1'b0, 32'h0, 32'h0, 1, n, done);
    check_fin("single_load", n, done, 3, 32'h37, 32'h0);
    release_lanes();
  endtask

  task automatic test_dual_same_addr();
    int n; bit done;
    drive_bundle(1'b1, 1'b1, 32'h10, 32'hAA, 1, 1'b1, 1'b0, 32'h10, 32'h0, 1, n, done);
    check_fin("dual_same_addr", n, done, 3, 32'h37, 32'hAA);
    release_lanes();
  endtask

  task automatic test_lane1_only();
    int n; bit done;
    drive_bundle(1'b0, 1'b0, 32'h0, 32'h0, 1, 1'b1, 1'b1, 32'h4, 32'h5, 2, n, done);
    check_fin("lane1_only", n, done, 3, 32'h37, 32'hAA);
    release_lanes();
  endtask

  task automatic test_back_to_back();
    int n; bit done;
    drive_bundle(1'b1, 1'b0, 32'h4, 32'h0, 1, 1'b1, 1'b0, 32'h8, 32'h0, 2, n, done);
    check_fin("b2b_first", n, done, 4, 32'h5, 32'h37);
    @(posedge clk); #1;
    drive_bundle(1'b1, 1'b0, 32'h10, 32'h0, 3, 1'b1, 1'b0, 32'h4, 32'h0, 1, n, done);
    check_fin("b2b_second", n, done, 5, 32'hAA, 32'h5);
    release_lanes();
    #1;
    checks++;
    if (l0_rdata !== 32'hAA || l1_rdata !== 32'h5 || stall !== 1'b0) begin
      failures++; $display("FAIL b2b_after: got r0=%h r1=%h stall=%b, expected aa 5 0", l0_rdata, l1_rdata, stall);
    end
  endtask

  task automatic test_reset_mid_access();
    int n; bit done;
    l0_req = 1'b1; l0_we = 1'b0; l0_addr = 32'h8; l0_wdata = 32'h0;
    sb.push_back('{1'b0, 32'h8, 32'h0, 50});
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (mem_req !== 1'b1) begin failures++; $display("FAIL midrst_busy: got mem_req=%b, expected 1", mem_req); end
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_req, stall} !== 2'b00) begin
      failures++; $display("FAIL midrst_outputs: got mem_req=%b stall=%b, expected 0 0", mem_req, stall);
    end
    checks++;
    if ({stall_cnt, l0_rdata, l1_rdata} !== 80'h0) begin
      failures++; $display("FAIL midrst_regs: got cnt=%h r0=%h r1=%h, expected all 0", stall_cnt, l0_rdata, l1_rdata);
    end
    sb.delete();
    exp_cnt = 0;
    l0_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    force_ready = 1'b1;
    @(posedge clk); #1;
    force_ready = 1'b0;
    repeat (2) begin
      checks++;
      if ({mem_req, stall, l0_rdata, l1_rdata} !== 66'h0) begin
        failures++; $display("FAIL midrst_ignored_ready: got mem_req=%b stall=%b r0=%h r1=%h, expected all 0",
                             mem_req, stall, l0_rdata, l1_rdata);
      end
      @(posedge clk); #1;
    end
    drive_bundle(1'b0, 1'b0, 32'h0, 32'h0, 1, 1'b1, 1'b0, 32'h10, 32'h0, 1, n, done);
    check_fin("midrst_recover", n, done, 2, 32'h0, 32'hAA);
    release_lanes();
  endtask

  task automatic test_counter_saturation();
    int to_fffe;
    l0_req = 1'b1; l0_we = 1'b0; l0_addr = 32'h20; l0_wdata = 32'h0;
    sb.push_back('{1'b0, 32'h20, 32'h0, 1000000});
    to_fffe = 32'hFFFE - exp_cnt;
    repeat (to_fffe) @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 16'hFFFE) begin failures++; $display("FAIL sat_below: got %h, expected fffe", stall_cnt); end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hold: got %h, expected ffff", stall_cnt); end
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL sat_stall: got %b, expected 1", stall); end
    reset = 1'b0;
    l0_req = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    mem[32'h8] = 32'h37;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    fork
      responder();
    join_none
    @(posedge clk); #1;
    test_reset();
    test_single_load();
    test_dual_same_addr();
    test_lane1_only();
    test_back_to_back();
    test_reset_mid_access();
    test_counter_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
